path_sweep_ctrl: RTL and testbench

- Controller on the consumer side of the 8-way delay-path selector.
- Drives the 3-bit path select and waits for each path's finish flag, then captures its 32-bit delay count.
- A calibration sweep stores golden counts. A measurement sweep compares each path against its golden count and raises per-path trojan flags when the deviation exceeds a tolerance.
- Sits between the path selector and the readout/display logic.

---
 rtl/path_pkg.sv | 19 +
 rtl/path_cmp.sv | 30 +++
 rtl/path_sweep_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_path_sweep_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_pkg.sv
// Shared definitions for the delay-path sweep controller.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package path_pkg;

    localparam int NPATH_DEF = 8;
    localparam int RES_W_DEF = 32;
    localparam int SEL_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT_FIN,
        S_CAPTURE,
        S_NEXT,
        S_FINISH
    } sweep_state_t;

endpackage

// File: rtl/path_cmp.sv
// Flags a path whose delay count differs from its golden count by more than TOL.
// Latency: combinational.
// Backpressure: none.
// Ports: result/golden = counts being compared; dev = |result - golden| > TOL.
module path_cmp
    import path_pkg::*;
#(
    parameter int RES_W = RES_W_DEF,
    parameter int TOL   = 2
) (
    input  logic [RES_W-1:0] result,
    input  logic [RES_W-1:0] golden,
    output logic             dev
);

    localparam logic [RES_W:0] TOL_V = (RES_W+1)'(TOL);

    // One extra bit so the subtraction of two full-range counts cannot wrap.
    logic [RES_W:0] abs_diff;

    always_comb begin
        if (result >= golden) begin
            abs_diff = {1'b0, result} - {1'b0, golden};
        end else begin
            abs_diff = {1'b0, golden} - {1'b0, result};
        end
        dev = (abs_diff > TOL_V);
    end

endmodule

// File: rtl/path_sweep_ctrl.sv
// Sweeps the delay-path selector, captures each path's count, calibrates or compares to golden.
// Latency: per path SETTLE_CYC + cycles-until-fin + 2; sweep ends with a one-cycle done.
// Backpressure: waits on path_fin per path; start while busy is dropped (no queuing).
// Ports: clk250/rst_n (async active-low); start+cal launch a sweep; sw_sel drives the selector;
//        path_result/path_fin come back from it; busy/done/flag_mask/trojan_flag/golden_valid report;
//        rd_idx/rd_data give a combinational readout of the last captured counts.
// Optional: define PATH_TIMEOUT_EN to bound the wait for path_fin (adds timeout_err port).
module path_sweep_ctrl
    import path_pkg::*;
#(
    parameter int NPATH      = NPATH_DEF,
    parameter int RES_W      = RES_W_DEF,
    parameter int SETTLE_CYC = 4,
    parameter int TOL        = 2
`ifdef PATH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input  logic                     clk250,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cal,
    output logic [$clog2(NPATH)-1:0] sw_sel,
    input  logic [RES_W-1:0]         path_result,
    input  logic                     path_fin,
    output logic                     busy,
    output logic                     done,
    output logic [NPATH-1:0]         flag_mask,
    output logic                     trojan_flag,
    output logic                     golden_valid,
`ifdef PATH_TIMEOUT_EN
    output logic                     timeout_err,
`endif
    input  logic [$clog2(NPATH)-1:0] rd_idx,
    output logic [RES_W-1:0]         rd_data
);

    localparam int SW = $clog2(NPATH);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);

    sweep_state_t     state, state_nxt;
    logic [SW-1:0]    idx;
    logic [CW-1:0]    settle_cnt;
    logic             mode_cal;
    logic [RES_W-1:0] cap    [NPATH];
    logic [RES_W-1:0] golden [NPATH];
    logic [RES_W-1:0] cap_val;
    logic             dev;
    logic             to_expire;
    logic             last_path;

    assign last_path = (idx == SW'(NPATH - 1));
    assign sw_sel    = idx;
    assign rd_data   = cap[rd_idx];

`ifdef PATH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;
    logic          to_hit;

    // Fires on the TIMEOUT_CYC-th consecutive WAIT_FIN cycle with fin low.
    assign to_expire = (state == S_WAIT_FIN) && !path_fin && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign cap_val   = to_hit ? '0 : path_result;
`else
    assign to_expire = 1'b0;
    assign cap_val   = path_result;
`endif

    path_cmp #(
        .RES_W (RES_W),
        .TOL   (TOL)
    ) u_cmp (
        .result (cap_val),
        .golden (golden[idx]),
        .dev    (dev)
    );

    always_ff @(posedge clk250 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                // path_fin may still be high from the previous path; it is not looked at here.
                if (settle_cnt == '0) state_nxt = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                busy = 1'b1;
                if (path_fin || to_expire) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy      = 1'b1;
                state_nxt = S_NEXT;
            end
            S_NEXT: begin
                busy      = 1'b1;
                state_nxt = last_path ? S_FINISH : S_SETTLE;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk250 or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            settle_cnt   <= '0;
            mode_cal     <= 1'b0;
            flag_mask    <= '0;
            trojan_flag  <= 1'b0;
            golden_valid <= 1'b0;
            for (int i = 0; i < NPATH; i++) begin
                cap[i]    <= '0;
                golden[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_cal   <= cal;
                        idx        <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        // Only a measurement sweep owns the flags; calibration leaves them alone.
                        if (!cal) begin
                            flag_mask   <= '0;
                            trojan_flag <= 1'b0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                S_CAPTURE: begin
                    cap[idx] <= cap_val;
                    if (mode_cal) begin
                        golden[idx] <= cap_val;
                    end else begin
                        flag_mask[idx] <= dev;
                    end
`ifdef PATH_TIMEOUT_EN
                    if (to_hit) flag_mask[idx] <= 1'b1;
`endif
                end
                S_NEXT: begin
                    if (last_path) begin
                        // Status is updated here so it is already visible while done pulses.
                        if (mode_cal) begin
                            golden_valid <= 1'b1;
                        end else begin
                            trojan_flag <= |flag_mask;
                        end
                    end else begin
                        idx        <= idx + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PATH_TIMEOUT_EN
    always_ff @(posedge clk250 or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            to_hit      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) timeout_err <= 1'b0;
                end
                S_SETTLE: begin
                    to_cnt <= '0;
                    to_hit <= 1'b0;
                end
                S_WAIT_FIN: begin
                    to_cnt <= to_cnt + 1'b1;
                    to_hit <= to_expire;
                end
                S_CAPTURE: begin
                    if (to_hit) timeout_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_path_sweep_ctrl.sv
// Directed bench for path_sweep_ctrl with a behavioural 8-way selector model.
module tb_path_sweep_ctrl;
    import path_pkg::*;

    localparam int NP = 8;
    localparam int RW = 32;
    localparam int SC = 4;
    localparam int TL = 2;
    localparam int MIN_SWEEP = NP * (SC + 3) + 1;

    logic             clk250 = 1'b0;
    logic             rst_n;
    logic             start;
    logic             cal;
    logic [SEL_W-1:0] sw_sel;
    logic [RW-1:0]    path_result = '0;
    logic             path_fin = 1'b0;
    logic             busy;
    logic             done;
    logic [NP-1:0]    flag_mask;
    logic             trojan_flag;
    logic             golden_valid;
    logic [SEL_W-1:0] rd_idx;
    logic [RW-1:0]    rd_data;
`ifdef PATH_TIMEOUT_EN
    logic             timeout_err;
`endif

    always #5 clk250 = ~clk250;

    path_sweep_ctrl #(
        .NPATH      (NP),
        .RES_W      (RW),
        .SETTLE_CYC (SC),
        .TOL        (TL)
`ifdef PATH_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (50)
`endif
    ) dut (
        .clk250       (clk250),
        .rst_n        (rst_n),
        .start        (start),
        .cal          (cal),
        .sw_sel       (sw_sel),
        .path_result  (path_result),
        .path_fin     (path_fin),
        .busy         (busy),
        .done         (done),
        .flag_mask    (flag_mask),
        .trojan_flag  (trojan_flag),
        .golden_valid (golden_valid),
`ifdef PATH_TIMEOUT_EN
        .timeout_err  (timeout_err),
`endif
        .rd_idx       (rd_idx),
        .rd_data      (rd_data)
    );

    // Selector model: count for the selected path, fin rises fin_age cycles after a select change.
    logic [RW-1:0] res_tab [NP];
    int            fin_age    = 6;
    bit            fin_always = 1'b0;
    int            dead_path  = -1;
    int            age        = 0;
    logic [SEL_W-1:0] last_sel = '0;

    always @(negedge clk250) begin
        if (sw_sel != last_sel) age = 0;
        else if (age < 10000) age = age + 1;
        last_sel    = sw_sel;
        path_result = res_tab[sw_sel];
        path_fin    = fin_always || ((int'(sw_sel) != dead_path) && (age >= fin_age));
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rd(input int i, input logic [RW-1:0] exp, input string tag);
        rd_idx = SEL_W'(i);
        #1;
        check($sformatf("%s rd_data[%0d]", tag, i), rd_data, exp);
    endtask

    // Results of the last sweep.
    int  sw_cyc;
    int  sw_dones;
    bit  sw_seq_ok;
    bit  sw_busy_first;
    bit  sw_busy_at_done;
    int  sw_per [NP];
    int  inject_at = -1;

    task automatic run_sweep(input logic c);
        bit got_done;
        int exp_sel;
        @(negedge clk250);
        start = 1'b1;
        cal   = c;
        @(negedge clk250);
        start           = 1'b0;
        sw_cyc          = 0;
        sw_dones        = 0;
        sw_seq_ok       = 1'b1;
        sw_busy_at_done = 1'b1;
        sw_busy_first   = busy;
        got_done        = 1'b0;
        exp_sel         = 0;
        for (int i = 0; i < NP; i++) sw_per[i] = 0;
        for (int n = 0; n < 3000 && !got_done; n++) begin
            sw_cyc++;
            if (busy) sw_per[sw_sel]++;
            if (int'(sw_sel) != exp_sel) begin
                if (int'(sw_sel) == exp_sel + 1) exp_sel++;
                else sw_seq_ok = 1'b0;
            end
            if (done) begin
                got_done        = 1'b1;
                sw_dones++;
                sw_busy_at_done = busy;
            end else begin
                start = (sw_cyc == inject_at);
                if (start) cal = 1'b0;
                @(negedge clk250);
            end
        end
        start = 1'b0;
        if (exp_sel != NP - 1) sw_seq_ok = 1'b0;
        check("sweep reaches done", got_done, 1'b1);
        repeat (3) begin
            @(negedge clk250);
            if (done) sw_dones++;
        end
    endtask

    typedef struct packed {
        logic                cal;
        logic [NP-1:0][RW-1:0] res;
        logic [NP-1:0]       exp_mask;
        logic                exp_trojan;
        logic                exp_gv;
    } vec_t;

    vec_t vecs [6];

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        cal    = 1'b0;
        rd_idx = '0;
        for (int i = 0; i < NP; i++) res_tab[i] = '0;

        for (int i = 0; i < NP; i++) begin
            vecs[0].res[i] = RW'(100 + i);
            vecs[1].res[i] = RW'(100 + i);
            vecs[2].res[i] = RW'(100 + i);
            vecs[3].res[i] = RW'(100 + i);
            vecs[4].res[i] = RW'(200 + i);
            vecs[5].res[i] = RW'(200 + i);
        end
        // calibration to 100+i
        vecs[0].cal = 1'b1; vecs[0].exp_mask = 8'h00; vecs[0].exp_trojan = 1'b0; vecs[0].exp_gv = 1'b1;
        // +2 and -2 against golden sit exactly at TOL: not flagged
        vecs[1].res[5] = 32'd107; vecs[1].res[2] = 32'd100;
        vecs[1].cal = 1'b0; vecs[1].exp_mask = 8'h00; vecs[1].exp_trojan = 1'b0; vecs[1].exp_gv = 1'b1;
        // path 3 far low, path 7 at +3
        vecs[2].res[3] = 32'd96; vecs[2].res[7] = 32'd110;
        vecs[2].cal = 1'b0; vecs[2].exp_mask = 8'h88; vecs[2].exp_trojan = 1'b1; vecs[2].exp_gv = 1'b1;
        // -3 on path 0; previous 0x88 must have been cleared
        vecs[3].res[0] = 32'd97; vecs[3].res[1] = 32'd103;
        vecs[3].cal = 1'b0; vecs[3].exp_mask = 8'h01; vecs[3].exp_trojan = 1'b1; vecs[3].exp_gv = 1'b1;
        // recalibration to 200+i leaves the flags untouched
        vecs[4].cal = 1'b1; vecs[4].exp_mask = 8'h01; vecs[4].exp_trojan = 1'b1; vecs[4].exp_gv = 1'b1;
        vecs[5].res[6] = 32'd250; vecs[5].res[4] = 32'd202;
        vecs[5].cal = 1'b0; vecs[5].exp_mask = 8'h40; vecs[5].exp_trojan = 1'b1; vecs[5].exp_gv = 1'b1;

        // Reset state
        repeat (3) @(negedge clk250);
        #1;
        check("reset sw_sel", sw_sel, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset flag_mask", flag_mask, 0);
        check("reset trojan_flag", trojan_flag, 0);
        check("reset golden_valid", golden_valid, 0);
        check_rd(0, '0, "reset");
        check_rd(7, '0, "reset");
        @(negedge clk250);
        rst_n = 1'b1;
        repeat (2) @(negedge clk250);

        // Table of sweeps
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NP; i++) res_tab[i] = vecs[v].res[i];
            run_sweep(vecs[v].cal);
            check($sformatf("v%0d busy after start", v), sw_busy_first, 1'b1);
            check($sformatf("v%0d done pulses", v), sw_dones, 1);
            check($sformatf("v%0d sw_sel sequence", v), sw_seq_ok, 1'b1);
            check($sformatf("v%0d busy at done", v), sw_busy_at_done, 1'b0);
            check($sformatf("v%0d flag_mask", v), flag_mask, vecs[v].exp_mask);
            check($sformatf("v%0d trojan_flag", v), trojan_flag, vecs[v].exp_trojan);
            check($sformatf("v%0d golden_valid", v), golden_valid, vecs[v].exp_gv);
            for (int i = 0; i < NP; i++) check_rd(i, vecs[v].res[i], $sformatf("v%0d", v));
        end

        // Stale fin held high: settle still enforced, minimum sweep length
        for (int i = 0; i < NP; i++) res_tab[i] = RW'(300 + i);
        fin_always = 1'b1;
        run_sweep(1'b1);
        fin_always = 1'b0;
        check("stale sweep cycles", sw_cyc, MIN_SWEEP);
        for (int i = 0; i < NP; i++) check($sformatf("stale path %0d cycles", i), sw_per[i], SC + 3);
        check("stale done pulses", sw_dones, 1);
        check("stale flag_mask kept", flag_mask, 8'h40);
        check_rd(4, 32'd304, "stale");

        // Reset while waiting for fin on path 4
        for (int i = 0; i < NP; i++) res_tab[i] = RW'(400 + i);
        @(negedge clk250);
        start = 1'b1;
        cal   = 1'b1;
        @(negedge clk250);
        start = 1'b0;
        begin
            bit seen4;
            seen4 = 1'b0;
            for (int n = 0; n < 400 && !seen4; n++) begin
                if (sw_sel == 3'd4) seen4 = 1'b1;
                else @(negedge clk250);
            end
            check("reached path 4", seen4, 1'b1);
        end
        repeat (4) @(negedge clk250);
        #1;
        check("pre-reset busy", busy, 1'b1);
        check("pre-reset flag_mask", flag_mask, 8'h40);
        @(negedge clk250);
        rst_n = 1'b0;
        #1;
        check("async reset sw_sel", sw_sel, 0);
        check("async reset busy", busy, 0);
        check("async reset done", done, 0);
        check("async reset flag_mask", flag_mask, 0);
        check("async reset trojan_flag", trojan_flag, 0);
        check("async reset golden_valid", golden_valid, 0);
        for (int i = 0; i < NP; i++) check_rd(i, '0, "async reset");
        @(negedge clk250);
        rst_n = 1'b1;
        repeat (3) @(negedge clk250);

        // Start while busy is dropped: calibration still completes unchanged
        for (int i = 0; i < NP; i++) res_tab[i] = RW'(300 + i);
        inject_at = 10;
        run_sweep(1'b1);
        inject_at = -1;
        check("ignored start done pulses", sw_dones, 1);
        check("ignored start sw_sel sequence", sw_seq_ok, 1'b1);
        // path 0 fin already stable (7 cycles), paths 1..7 wait 3 cycles for fin (9 cycles)
        check("ignored start sweep cycles", sw_cyc, 7 + 7 * 9 + 1);
        check("ignored start golden_valid", golden_valid, 1'b1);
        check_rd(0, 32'd300, "ignored start");
        check_rd(7, 32'd307, "ignored start");

`ifdef PATH_TIMEOUT_EN
        // Path 2 never finishes
        dead_path = 2;
        run_sweep(1'b0);
        dead_path = -1;
        check("timeout done pulses", sw_dones, 1);
        check("timeout_err set", timeout_err, 1'b1);
        check("timeout flag_mask", flag_mask, 8'h04);
        check("timeout trojan_flag", trojan_flag, 1'b1);
        check_rd(2, '0, "timeout");
        check_rd(3, 32'd303, "timeout");
        run_sweep(1'b0);
        check("timeout_err cleared by start", timeout_err, 1'b0);
        check("clean flag_mask after timeout", flag_mask, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
